// File: rtl/m_arb_pkg.sv
// Shared types and width helpers for the M-unit arbiter.
package m_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic {
        OUT_READY     = 1'b0,
        OUT_UNCLAIMED = 1'b1
    } outcome_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } m_req_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] rd;
    } m_resp_t;

    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter must be able to hold CLAIM_TIMEOUT itself.
    function automatic int cnt_w(input int t);
        return $clog2(t + 1);
    endfunction

endpackage

// File: rtl/m_rr_pick.sv
// Combinational round-robin selector: first set request after last_grant, wrapping.
module m_rr_pick
    import m_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int GRANT_W = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] last_grant,
    output logic [GRANT_W-1:0] grant,
    output logic               any_req
);

    function automatic int wrap(input int v);
        return (v >= NUM_REQ) ? v - NUM_REQ : v;
    endfunction

    // Walk offsets from farthest to nearest so the nearest set bit is written last.
    always_comb begin
        grant   = '0;
        any_req = |req;
        for (int off = NUM_REQ; off >= 1; off--) begin
            if (req[GRANT_W'(wrap(int'(last_grant) + off))])
                grant = GRANT_W'(wrap(int'(last_grant) + off));
        end
    end

endmodule

// File: rtl/m_unit_arbiter.sv
// Round-robin sharing of one PCPI-style M unit between NUM_REQ requesters,
// with explicit reporting of instructions the unit never claims.
module m_unit_arbiter
    import m_arb_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int CLAIM_TIMEOUT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0][31:0] req_instruction,
    input  logic [NUM_REQ-1:0][31:0] req_rs1,
    input  logic [NUM_REQ-1:0][31:0] req_rs2,
    output logic [NUM_REQ-1:0]      req_busy,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      req_unclaimed,
    output logic                    req_wr,
    output logic [31:0]             req_rd,
    output logic                    m_valid,
    output logic [31:0]             m_instruction,
    output logic [31:0]             m_rs1,
    output logic [31:0]             m_rs2,
    input  logic                    m_wr,
    input  logic [31:0]             m_rd,
    input  logic                    m_busy,
    input  logic                    m_ready
);

    localparam int GRANT_W = grant_w(NUM_REQ);
    localparam int CNT_W   = cnt_w(CLAIM_TIMEOUT);

    state_t             state;
    outcome_t           outcome;
    logic [GRANT_W-1:0] grant, last_grant, pick;
    logic               any_req;
    m_req_t             op_q;
    m_resp_t            resp_q;
    logic [CNT_W-1:0]   cnt;
    logic               claimed;
    logic               in_resp;

    m_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (pick),
        .any_req    (any_req)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            outcome    <= OUT_READY;
            grant      <= '0;
            last_grant <= GRANT_W'(NUM_REQ - 1);
            op_q       <= '0;
            resp_q     <= '0;
            cnt        <= '0;
            claimed    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant   <= pick;
                        op_q    <= '{instr: req_instruction[pick],
                                     rs1:   req_rs1[pick],
                                     rs2:   req_rs2[pick]};
                        cnt     <= '0;
                        claimed <= 1'b0;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // m_ready is checked first so a result on the timeout cycle still wins.
                    if (m_ready) begin
                        resp_q  <= '{wr: m_wr, rd: m_rd};
                        outcome <= OUT_READY;
                        state   <= RESP;
                    end else if (m_busy) begin
                        claimed <= 1'b1;
                    end else if (!claimed) begin
                        if (cnt == CNT_W'(CLAIM_TIMEOUT)) begin
                            resp_q  <= '0;
                            outcome <= OUT_UNCLAIMED;
                            state   <= RESP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RESP: begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_resp       = (state == RESP);
    assign m_valid       = (state == ISSUE);
    assign m_instruction = m_valid ? op_q.instr : '0;
    assign m_rs1         = m_valid ? op_q.rs1   : '0;
    assign m_rs2         = m_valid ? op_q.rs2   : '0;
    assign req_wr        = in_resp && (outcome == OUT_READY) && resp_q.wr;
    assign req_rd        = req_wr ? resp_q.rd : '0;

    // Busy is gated by reset so every requester-facing output reads 0 while reset is held.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign req_ready[i]     = in_resp && (outcome == OUT_READY) && (grant == GRANT_W'(i));
        assign req_unclaimed[i] = in_resp && (outcome == OUT_UNCLAIMED) && (grant == GRANT_W'(i));
        assign req_busy[i]      = !reset && req_valid[i] && !(in_resp && (grant == GRANT_W'(i)));
    end

endmodule

// File: tb/tb_m_unit_arbiter.sv
// Bench for m_unit_arbiter: behavioural M unit plus scoreboard of expected responses.
module tb_m_unit_arbiter;

    localparam int N = 2;
    localparam int T = 4;

    logic                clk, reset;
    logic [N-1:0]        req_valid;
    logic [N-1:0][31:0]  req_instruction, req_rs1, req_rs2;
    logic [N-1:0]        req_busy, req_ready, req_unclaimed;
    logic                req_wr;
    logic [31:0]         req_rd;
    logic                m_valid;
    logic [31:0]         m_instruction, m_rs1, m_rs2;
    logic                m_wr, m_busy, m_ready;
    logic [31:0]         m_rd;

    m_unit_arbiter #(.NUM_REQ(N), .CLAIM_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_instruction(req_instruction),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_busy(req_busy), .req_ready(req_ready), .req_unclaimed(req_unclaimed),
        .req_wr(req_wr), .req_rd(req_rd),
        .m_valid(m_valid), .m_instruction(m_instruction), .m_rs1(m_rs1), .m_rs2(m_rs2),
        .m_wr(m_wr), .m_rd(m_rd), .m_busy(m_busy), .m_ready(m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Unit model: mode 0 readies at u_delay, 1 never responds, 2 busy from cycle 1 then readies.
    int          u_mode = 0;
    int          u_delay = 3;
    int          u_cnt = 0;
    logic [31:0] u_res;

    always @(posedge clk) u_cnt <= m_valid ? u_cnt + 1 : 0;

    always_comb begin
        u_res = 32'h0;
        case (m_instruction[14:12])
            3'd0:    u_res = m_rs1 * m_rs2;
            3'd4:    u_res = (m_rs2 != 32'h0) ? m_rs1 / m_rs2 : 32'hFFFF_FFFF;
            default: u_res = 32'h0;
        endcase
    end

    assign m_ready = m_valid && (u_mode != 1) && (u_cnt == u_delay);
    assign m_busy  = m_valid && (u_mode == 2) && (u_cnt >= 1) && !m_ready;
    assign m_wr    = m_ready;
    assign m_rd    = m_ready ? u_res : 32'h0;

    typedef struct {
        int          idx;
        bit          unc;
        logic        wr;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   t0;

    localparam logic [31:0] MUL = 32'h02B50533;
    localparam logic [31:0] DIV = 32'h02B54533;
    localparam logic [31:0] ADD = 32'h00B50533;

    function automatic logic [2*N+32:0] exp_vec(input exp_t x);
        logic [N-1:0] one;
        one = 1;
        return {x.unc ? '0 : (one << x.idx), x.unc ? (one << x.idx) : '0, x.wr, x.rd};
    endfunction

    // Observations made by collect while waiting for a response pulse.
    logic [N-1:0] c_rdy, c_unc, c_bsy, c_bdrop;
    logic         c_wr;
    logic [31:0]  c_rd, c_mvrs1, c_mvrs2;
    int           c_tp, c_tmv;
    bit           c_to;

    task automatic collect(input int budget);
        c_rdy = '0; c_unc = '0; c_bsy = '0; c_bdrop = '0; c_wr = 1'b0; c_rd = '0;
        c_mvrs1 = '0; c_mvrs2 = '0; c_tp = -1; c_tmv = -1; c_to = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (m_valid && c_tmv < 0) begin
                c_tmv = cyc; c_mvrs1 = m_rs1; c_mvrs2 = m_rs2;
            end
            if ((req_ready | req_unclaimed) != '0) begin
                c_rdy = req_ready; c_unc = req_unclaimed; c_bsy = req_busy;
                c_wr = req_wr; c_rd = req_rd; c_tp = cyc; c_to = 1'b0;
                break;
            end
            c_bdrop |= req_valid & ~req_busy;
        end
    endtask

    task automatic drive(input int i, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        req_instruction[i] = ins; req_rs1[i] = a; req_rs2[i] = b; req_valid[i] = 1'b1;
    endtask

    task automatic wait_mvalid(input string nm);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (m_valid) break;
        end
        checks++;
        if (m_valid !== 1'b1) begin errors++; $display("FAIL %s m_valid=%b required 1", nm, m_valid); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mvalid got=%b exp=0", m_valid); end
        checks++;
        if ({m_instruction, m_rs1, m_rs2} !== 96'h0) begin errors++; $display("FAIL rst_mbus got=%h exp=0", {m_instruction, m_rs1, m_rs2}); end
        checks++;
        if ({req_ready, req_unclaimed, req_busy} !== '0) begin errors++; $display("FAIL rst_req got=%b exp=0", {req_ready, req_unclaimed, req_busy}); end
        checks++;
        if ({req_wr, req_rd} !== 33'h0) begin errors++; $display("FAIL rst_resp got=%h exp=0", {req_wr, req_rd}); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_mul();
        u_mode = 0; u_delay = 3;
        @(negedge clk);
        t0 = cyc;
        drive(0, MUL, 32'd7, 32'd6);
        sb.push_back('{idx: 0, unc: 1'b0, wr: 1'b1, rd: 32'd42});
        collect(20);
        checks++;
        if (c_to) begin errors++; $display("FAIL mul_timeout no pulse within 20 cycles"); end
        checks++;
        if (c_tmv != t0 + 1) begin errors++; $display("FAIL mul_mvalid_lat got=%0d exp=%0d", c_tmv, t0 + 1); end
        checks++;
        if ({c_mvrs1, c_mvrs2} !== {32'd7, 32'd6}) begin errors++; $display("FAIL mul_operands got=%0d,%0d exp=7,6", c_mvrs1, c_mvrs2); end
        checks++;
        if (c_tp != c_tmv + 4) begin errors++; $display("FAIL mul_ready_lat got=%0d exp=%0d", c_tp, c_tmv + 4); end
        checks++;
        if (c_bdrop !== '0 || c_bsy[0] !== 1'b0) begin errors++; $display("FAIL mul_busy drop=%b at_pulse=%b exp 0,0", c_bdrop, c_bsy[0]); end
        e = sb.pop_front(); checks++;
        if ({c_rdy, c_unc, c_wr, c_rd} !== exp_vec(e)) begin errors++; $display("FAIL mul_resp got=%h exp=%h", {c_rdy, c_unc, c_wr, c_rd}, exp_vec(e)); end
        req_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== '0) begin errors++; $display("FAIL mul_pulse_once req_ready=%b exp=0", req_ready); end
    endtask

    task automatic test_simultaneous();
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        u_mode = 0; u_delay = 2;
        @(negedge clk);
        drive(0, DIV, 32'd100, 32'd7);
        drive(1, MUL, 32'd3, 32'd5);
        sb.push_back('{idx: 0, unc: 1'b0, wr: 1'b1, rd: 32'd14});
        sb.push_back('{idx: 1, unc: 1'b0, wr: 1'b1, rd: 32'd15});
        collect(20);
        e = sb.pop_front(); checks++;
        if (c_to || {c_rdy, c_unc, c_wr, c_rd} !== exp_vec(e)) begin errors++; $display("FAIL sim_first got=%h exp=%h to=%0d", {c_rdy, c_unc, c_wr, c_rd}, exp_vec(e), c_to); end
        checks++;
        if (c_bdrop !== '0 || c_bsy[1] !== 1'b1) begin errors++; $display("FAIL sim_busy1 drop=%b busy_at_pulse=%b exp 00,1", c_bdrop, c_bsy[1]); end
        req_valid[0] = 1'b0;
        wait_mvalid("sim_second_issue");
        req_rs1[1] = 32'd99; req_rs2[1] = 32'd99;
        collect(20);
        checks++;
        if ({c_mvrs1, c_mvrs2} !== {32'd3, 32'd5}) begin errors++; $display("FAIL sim_latched_ops got=%0d,%0d exp=3,5", c_mvrs1, c_mvrs2); end
        e = sb.pop_front(); checks++;
        if (c_to || {c_rdy, c_unc, c_wr, c_rd} !== exp_vec(e)) begin errors++; $display("FAIL sim_second got=%h exp=%h to=%0d", {c_rdy, c_unc, c_wr, c_rd}, exp_vec(e), c_to); end
        req_valid[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fairness();
        // Previous grant was requester 1, so order must be 0,1,0,1.
        u_mode = 0; u_delay = 2;
        drive(0, MUL, 32'd1, 32'd10);
        drive(1, MUL, 32'd2, 32'd10);
        for (int n = 0; n < 4; n++)
            sb.push_back('{idx: n % 2, unc: 1'b0, wr: 1'b1, rd: 32'((n % 2 + 1) * 10)});
        for (int n = 0; n < 4; n++) begin
            collect(20);
            e = sb.pop_front(); checks++;
            if (c_to || {c_rdy, c_unc, c_wr, c_rd} !== exp_vec(e)) begin errors++; $display("FAIL fair_%0d got=%h exp=%h to=%0d", n, {c_rdy, c_unc, c_wr, c_rd}, exp_vec(e), c_to); end
            req_valid[e.idx] = 1'b0;
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b0) begin errors++; $display("FAIL fair_gap_%0d m_valid=%b exp=0", n, m_valid); end
            if (n < 3) req_valid[e.idx] = 1'b1;
        end
        req_valid = '0;
    endtask

    task automatic test_unclaimed();
        u_mode = 1;
        @(negedge clk);
        drive(1, ADD, 32'd1, 32'd2);
        sb.push_back('{idx: 1, unc: 1'b1, wr: 1'b0, rd: 32'd0});
        collect(30);
        checks++;
        if (c_to || c_tp != c_tmv + T + 1) begin errors++; $display("FAIL unc_lat got=%0d exp=%0d to=%0d", c_tp - c_tmv, T + 1, c_to); end
        e = sb.pop_front(); checks++;
        if ({c_rdy, c_unc, c_wr, c_rd} !== exp_vec(e)) begin errors++; $display("FAIL unc_resp got=%h exp=%h", {c_rdy, c_unc, c_wr, c_rd}, exp_vec(e)); end
        req_valid[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_claim_slow();
        u_mode = 2; u_delay = 40;
        drive(0, MUL, 32'd2, 32'd3);
        sb.push_back('{idx: 0, unc: 1'b0, wr: 1'b1, rd: 32'd6});
        collect(80);
        checks++;
        if (c_to || c_tp != c_tmv + 41) begin errors++; $display("FAIL claim_lat got=%0d exp=41 to=%0d", c_tp - c_tmv, c_to); end
        e = sb.pop_front(); checks++;
        if ({c_rdy, c_unc, c_wr, c_rd} !== exp_vec(e)) begin errors++; $display("FAIL claim_resp got=%h exp=%h", {c_rdy, c_unc, c_wr, c_rd}, exp_vec(e)); end
        req_valid[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_boundary();
        u_mode = 0; u_delay = T;
        drive(1, MUL, 32'd9, 32'd9);
        sb.push_back('{idx: 1, unc: 1'b0, wr: 1'b1, rd: 32'd81});
        collect(30);
        checks++;
        if (c_to || c_tp != c_tmv + T + 1) begin errors++; $display("FAIL bnd_lat got=%0d exp=%0d to=%0d", c_tp - c_tmv, T + 1, c_to); end
        e = sb.pop_front(); checks++;
        if ({c_rdy, c_unc, c_wr, c_rd} !== exp_vec(e)) begin errors++; $display("FAIL bnd_resp got=%h exp=%h", {c_rdy, c_unc, c_wr, c_rd}, exp_vec(e)); end
        req_valid[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        u_mode = 0; u_delay = 20;
        drive(0, MUL, 32'd8, 32'd8);
        wait_mvalid("rmid_issue");
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL rmid_mvalid got=%b exp=0", m_valid); end
        checks++;
        if ({req_ready, req_unclaimed, req_busy, req_wr} !== '0 || req_rd !== 32'h0) begin errors++; $display("FAIL rmid_req got=%b rd=%h exp=0", {req_ready, req_unclaimed, req_busy, req_wr}, req_rd); end
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        u_delay = 2;
        @(negedge clk);
        drive(1, MUL, 32'd4, 32'd4);
        drive(0, MUL, 32'd5, 32'd5);
        sb.push_back('{idx: 0, unc: 1'b0, wr: 1'b1, rd: 32'd25});
        sb.push_back('{idx: 1, unc: 1'b0, wr: 1'b1, rd: 32'd16});
        for (int n = 0; n < 2; n++) begin
            collect(20);
            e = sb.pop_front(); checks++;
            if (c_to || {c_rdy, c_unc, c_wr, c_rd} !== exp_vec(e)) begin errors++; $display("FAIL rmid_after_%0d got=%h exp=%h to=%0d", n, {c_rdy, c_unc, c_wr, c_rd}, exp_vec(e), c_to); end
            req_valid[e.idx] = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_empty left=%0d exp=0", sb.size()); end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0; req_instruction = '0; req_rs1 = '0; req_rs2 = '0;
        test_reset();
        test_single_mul();
        test_simultaneous();
        test_fairness();
        test_unclaimed();
        test_claim_slow();
        test_boundary();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/m_unit_arbiter.md
Name: m_unit_arbiter

Overview:
- Shares one PCPI-style M-extension unit (valid/instruction/rs1/rs2 in; wr/rd/busy/ready out) between NUM_REQ requesters, e.g. two core PCPI ports or a core plus a DMA/test engine.
- Grants are round-robin. The granted request's operands are latched, and a single M-unit transaction is sequenced from issue to result return.
- Instructions the unit never claims are detected and reported explicitly, so requesters need no timeout of their own.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- CLAIM_TIMEOUT, 4, cycles in ISSUE without m_busy/m_ready before the request is declared unclaimed (>=2).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held high until that requester's req_ready or req_unclaimed.
- req_instruction  in  NUM_REQ*32  packed; slice i belongs to requester i.
- req_rs1  in  NUM_REQ*32  packed operand 1.
- req_rs2  in  NUM_REQ*32  packed operand 2.
- req_busy  out  NUM_REQ  request accepted and pending (granted or queued).
- req_ready  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- req_unclaimed  out  NUM_REQ  one-cycle pulse: instruction was not claimed by the unit.
- req_wr  out  1  shared; valid only with a req_ready pulse.
- req_rd  out  32  shared result; 0 except when req_ready and req_wr are both high.
- m_valid  out  1  to the unit.
- m_instruction  out  32  to the unit.
- m_rs1  out  32  to the unit.
- m_rs2  out  32  to the unit.
- m_wr  in  1  from the unit.
- m_rd  in  32  from the unit.
- m_busy  in  1  from the unit.
- m_ready  in  1  from the unit.

Behaviour:
- Reset values:
  - state=IDLE; last_grant=NUM_REQ-1, so requester 0 wins first.
  - All outputs 0: m_valid, m_instruction, m_rs1, m_rs2, req_*.
  - Claim counter 0; claimed flag 0.
- IDLE:
  - If any req_valid is high, pick the first set bit searching from last_grant+1 with wrap-around.
  - Latch grant index, instruction, rs1 and rs2; clear counter and claimed flag; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - m_valid=1, with m_* driven from the latched registers only (requester inputs are ignored after latch).
  - If m_ready: capture m_wr and m_rd, then go to RESP with the ready outcome. m_ready wins over a timeout in the same cycle.
  - Else if m_busy: set claimed; the counter freezes.
  - Else if !claimed: increment the counter. On reaching CLAIM_TIMEOUT, go to RESP with the unclaimed outcome.
  - A claimed op waits indefinitely for m_ready.
- RESP (exactly 1 cycle):
  - m_valid=0.
  - Ready outcome: req_ready[grant]=1, req_wr=captured m_wr, req_rd=captured m_rd (forced to 0 if !m_wr).
  - Unclaimed outcome: req_unclaimed[grant]=1, req_wr=0, req_rd=0.
  - last_grant<=grant; go to IDLE.
  - The requester must drop req_valid by the next edge. The arbiter does not re-sample the same requester until the IDLE cycle.
- req_busy[i] = req_valid[i] && !(state==RESP && grant==i). Queued requesters are therefore held busy while another is served.
- Latency:
  - Request seen in IDLE at cycle t: m_valid rises at t+1.
  - m_ready at cycle k: req_ready at k+1.
  - The arbiter adds 2 cycles to the unit's latency.
  - m_valid is guaranteed low for at least 2 cycles between transactions (RESP + IDLE), so the unit returns to idle.
- Fairness: with all requesters continuously valid, grants cycle 0,1,..,NUM_REQ-1,0.
- Reset mid-operation: immediate return to IDLE with m_valid=0. No response pulse for the aborted request; the requester re-requests.
- m_ready without m_valid (outside ISSUE): ignored.

Decomposition:
- Package m_arb_pkg:
  - state enum {IDLE, ISSUE, RESP};
  - outcome enum {OUT_READY, OUT_UNCLAIMED};
  - GRANT_W=$clog2(NUM_REQ) helper;
  - CNT_W derived from CLAIM_TIMEOUT.
- Sub-module m_rr_pick: combinational round-robin priority selector.
  - Inputs: req vector, last_grant.
  - Outputs: grant index, any_req.

Test Plan:
- Single request, MUL: req0 instr=0x02B50533 (mul), rs1=7, rs2=6; model unit readies after 3 cycles with wr=1, rd=42 -> m_valid at t+1, m_rs1=7, m_rs2=6; req_ready[0] pulses once with req_rd=42, req_wr=1; req_busy[0] high until then.
- Simultaneous requests after reset: req0 DIV 0x02B54533 (rs1=100, rs2=7), req1 MUL (rs1=3, rs2=5) -> req0 served first (rd=14), then req1 (rd=15); req_busy[1] high throughout the wait; req1's operands changed mid-wait are ignored.
- Unclaimed: req1 ADD 0x00B50533; unit never asserts busy/ready -> req_unclaimed[1] pulses exactly CLAIM_TIMEOUT+1 cycles after m_valid rises; req_ready stays 0; req_rd=0.
- Claim then slow result: unit asserts m_busy in cycle 1 of ISSUE, m_ready after 40 cycles -> no unclaimed pulse; req_ready after 41 cycles; counter frozen.
- Boundary: m_ready arrives in the same cycle the counter hits CLAIM_TIMEOUT -> ready outcome, captured rd delivered, no unclaimed pulse.
- Reset during ISSUE with req0 active -> m_valid=0 and all req_* =0 asynchronously; after release, req1 and req0 both valid -> req0 granted first (last_grant reset).
